// File: rtl/rv32i_alu_issue_ctrl.sv
// Issue controller between decode and the rv32i ALU: small packet FIFO plus RUN/STALL/FLUSH
// sequencing of the ALU ce/stall/flush controls. Define RV32I_ISSUE_PERF_EN to add perf counters.
module rv32i_alu_issue_ctrl #(
  parameter int PKT_W        = 64,
  parameter int DEPTH        = 2,
  parameter int FLUSH_CYCLES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_dec_valid,
  output logic             o_dec_ready,
  input  logic [PKT_W-1:0] i_dec_pkt,
  output logic [PKT_W-1:0] o_alu_pkt,
  output logic             o_alu_ce,
  output logic             o_alu_stall,
  output logic             o_alu_flush,
  input  logic             i_alu_stall_req,
  input  logic             i_alu_change_pc,
  input  logic             i_wb_stall,
  input  logic             i_force_stall,
  output logic             o_busy
`ifdef RV32I_ISSUE_PERF_EN
  ,
  output logic [31:0]      o_stall_cycles,
  output logic [15:0]      o_flush_count,
  output logic [31:0]      o_issue_count
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

  state_t           state, state_nxt;
  logic [PKT_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0] head, tail;
  logic [CNT_W-1:0] count;
  logic [2:0]       flush_cnt;
  logic             stall_any, empty, full, enter_flush, issue, push;

  assign stall_any   = i_wb_stall | i_alu_stall_req | i_force_stall;
  assign empty       = (count == '0);
  assign full        = (count == CNT_W'(DEPTH));
  assign enter_flush = (state != FLUSH) & i_alu_change_pc;
  // A taken branch squashes the head too, so change_pc outranks issue.
  assign issue       = (state == RUN) & !empty & !stall_any & !i_alu_change_pc;
  // A push landing on the flush-entry edge belongs to the squashed path.
  assign push        = i_dec_valid & o_dec_ready & !enter_flush;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state <= state_nxt;
      if (enter_flush)
        flush_cnt <= 3'(FLUSH_CYCLES);
      else if (state == FLUSH)
        flush_cnt <= flush_cnt - 3'd1;
    end
  end

  // NOTE: every comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      RUN:     if (i_alu_change_pc) state_nxt = FLUSH;
               else if (stall_any)  state_nxt = STALL;
      STALL:   if (i_alu_change_pc) state_nxt = FLUSH;
               else if (!stall_any) state_nxt = RUN;
      FLUSH:   if (flush_cnt == 3'd1) state_nxt = stall_any ? STALL : RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    o_alu_ce    = issue;
    o_alu_stall = i_rst_n & stall_any;
    o_alu_flush = (state == FLUSH);
    o_dec_ready = i_rst_n & (state != FLUSH) & (!full | issue);
    o_alu_pkt   = empty ? '0 : mem[head];
    o_busy      = !empty | (state != RUN);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (enter_flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (issue)
        head <= (head == PTR_W'(DEPTH - 1)) ? '0 : head + 1'b1;
      if (push)
        tail <= (tail == PTR_W'(DEPTH - 1)) ? '0 : tail + 1'b1;
      case ({push, issue})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: packet storage has no reset; count gates visibility, so stale contents are never observed.
  always_ff @(posedge i_clk) begin
    if (push)
      mem[tail] <= i_dec_pkt;
  end

`ifdef RV32I_ISSUE_PERF_EN
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_stall_cycles <= '0;
      o_flush_count  <= '0;
      o_issue_count  <= '0;
    end else begin
      if ((state == STALL) && (o_stall_cycles != '1))
        o_stall_cycles <= o_stall_cycles + 32'd1;
      if (enter_flush && (o_flush_count != '1))
        o_flush_count <= o_flush_count + 16'd1;
      if (issue && (o_issue_count != '1))
        o_issue_count <= o_issue_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_rv32i_alu_issue_ctrl.sv
// Randomized bench for rv32i_alu_issue_ctrl against a queue-based behavioural model.
// Honours RV32I_ISSUE_PERF_EN the same way as the design.
module tb_rv32i_alu_issue_ctrl;

  localparam int DEPTH        = 2;
  localparam int FLUSH_CYCLES = 2;

  logic        clk, rst_n;
  logic        dec_valid, dec_ready;
  logic [63:0] dec_pkt, alu_pkt;
  logic        alu_ce, alu_stall, alu_flush;
  logic        alu_stall_req, alu_change_pc, wb_stall, force_stall, busy;
`ifdef RV32I_ISSUE_PERF_EN
  logic [31:0] stall_cycles, issue_count;
  logic [15:0] flush_count;
`endif

  rv32i_alu_issue_ctrl #(.PKT_W(64), .DEPTH(DEPTH), .FLUSH_CYCLES(FLUSH_CYCLES)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_dec_valid(dec_valid), .o_dec_ready(dec_ready), .i_dec_pkt(dec_pkt),
    .o_alu_pkt(alu_pkt), .o_alu_ce(alu_ce), .o_alu_stall(alu_stall), .o_alu_flush(alu_flush),
    .i_alu_stall_req(alu_stall_req), .i_alu_change_pc(alu_change_pc),
    .i_wb_stall(wb_stall), .i_force_stall(force_stall), .o_busy(busy)
`ifdef RV32I_ISSUE_PERF_EN
    , .o_stall_cycles(stall_cycles), .o_flush_count(flush_count), .o_issue_count(issue_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: packet queue, flush cycles remaining, and whether issue is held by a stall.
  logic [63:0] mq[$];
  int          flush_left;
  bit          stalled;
  longint      m_stalls, m_flushes, m_issues;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    flush_left = 0;
    stalled    = 1'b0;
    m_stalls   = 0;
    m_flushes  = 0;
    m_issues   = 0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 64'(dec_ready), 64'd0);
    check({tag, "_ce"},    64'(alu_ce),    64'd0);
    check({tag, "_stall"}, 64'(alu_stall), 64'd0);
    check({tag, "_flush"}, 64'(alu_flush), 64'd0);
    check({tag, "_busy"},  64'(busy),      64'd0);
    check({tag, "_pkt"},   alu_pkt,        64'd0);
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance the model on the edge.
  task automatic step(input bit v, input logic [63:0] p, input bit wb, input bit ar,
                      input bit fs, input bit cpc);
    bit          any, flushing, e_ce, e_ready;
    logic [63:0] e_pkt;
    dec_valid     = v;
    dec_pkt       = p;
    wb_stall      = wb;
    alu_stall_req = ar;
    force_stall   = fs;
    alu_change_pc = cpc;
    #2;
    any      = wb | ar | fs;
    flushing = (flush_left > 0);
    e_ce     = !flushing && !stalled && (mq.size() > 0) && !any && !cpc;
    e_ready  = !flushing && ((mq.size() < DEPTH) || e_ce);
    e_pkt    = (mq.size() > 0) ? mq[0] : 64'd0;
    check("ce",    64'(alu_ce),    64'(e_ce));
    check("ready", 64'(dec_ready), 64'(e_ready));
    check("pkt",   alu_pkt,        e_pkt);
    check("flush", 64'(alu_flush), 64'(flushing));
    check("stall", 64'(alu_stall), 64'(any));
    check("busy",  64'(busy),      64'((mq.size() > 0) || flushing || stalled));
`ifdef RV32I_ISSUE_PERF_EN
    check("perf_stall", 64'(stall_cycles), 64'(m_stalls));
    check("perf_flush", 64'(flush_count),  64'(m_flushes));
    check("perf_issue", 64'(issue_count),  64'(m_issues));
`endif
    @(posedge clk);
    if (flushing) begin
      flush_left--;
      if (flush_left == 0) stalled = any;
    end else if (cpc) begin
      if (stalled) m_stalls++;
      mq.delete();
      flush_left = FLUSH_CYCLES;
      stalled    = 1'b0;
      m_flushes++;
    end else begin
      if (stalled) m_stalls++;
      if (e_ce) begin
        void'(mq.pop_front());
        m_issues++;
      end
      if (v && e_ready) mq.push_back(p);
      stalled = any;
    end
    #1;
  endtask

  function automatic logic [63:0] rnd_pkt();
    return {$urandom, $urandom};
  endfunction

  initial begin
    model_reset();
    rst_n         = 1'b0;
    dec_valid     = 1'b1;
    dec_pkt       = 64'hDEAD_BEEF_0000_0001;
    wb_stall      = 1'b0;
    alu_stall_req = 1'b0;
    force_stall   = 1'b0;
    alu_change_pc = 1'b0;

    // Reset held across an edge with a valid packet offered: nothing pushed, outputs low.
    #12;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_rel_ready", 64'(dec_ready), 64'd1);
    check("rst_rel_busy",  64'(busy),      64'd0);

    // Stream A,B,C without stalls.
    step(1, 64'hA, 0, 0, 0, 0);
    step(1, 64'hB, 0, 0, 0, 0);
    step(1, 64'hC, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0);

    // Back-pressure: fill under wb_stall, hold, then release and drain in order.
    step(1, 64'h11, 1, 0, 0, 0);
    step(1, 64'h22, 1, 0, 0, 0);
    step(1, 64'h33, 1, 0, 0, 0);
    step(1, 64'h44, 1, 0, 0, 0);
    repeat (4) step(0, 0, 0, 0, 0, 0);

    // Taken branch with two queued and a concurrent push.
    step(1, 64'h55, 0, 1, 0, 0);
    step(1, 64'h66, 0, 1, 0, 0);
    step(1, 64'h77, 0, 0, 0, 1);
    step(1, 64'h88, 0, 0, 0, 0);
    step(1, 64'h99, 0, 0, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    // Change_pc and force_stall together: flush first, stall on exit.
    step(1, 64'hAA, 0, 0, 1, 1);
    step(1, 64'hBB, 0, 0, 1, 1);
    step(1, 64'hCC, 0, 0, 1, 0);
    step(1, 64'hDD, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 3) != 0, rnd_pkt(), $urandom_range(0, 6) == 0,
           $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 14) == 0);

    // Reset asserted mid-activity, asynchronously between edges.
    step(1, rnd_pkt(), 0, 0, 0, 1);
    rst_n         = 1'b0;
    wb_stall      = 1'b1;
    alu_change_pc = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 500; i++)
      step($urandom_range(0, 1) != 0, rnd_pkt(), $urandom_range(0, 4) == 0,
           $urandom_range(0, 8) == 0, $urandom_range(0, 8) == 0, $urandom_range(0, 10) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
